ads5296_fclk_align: RTL

ADS5296_FCLK_ALIGN -- requirements
Module: ads5296_fclk_align

---
 rtl/ads5296_fclk_align.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/ads5296_fclk_align.sv
// ADS5296 frame-clock word aligner: finds the bit rotation that turns the
// deserialized frame clock into the expected pattern, locks on it, and tracks errors.
module ads5296_fclk_align #(
    parameter int                       G_FRAME_WIDTH  = 8,
    parameter logic [G_FRAME_WIDTH-1:0] G_FCLK_PATTERN = G_FRAME_WIDTH'(8'hF0),
    parameter int                       G_LOCK_COUNT   = 64,
    parameter int                       G_SLIP_WAIT    = 4,
    parameter int                       G_UNLOCK_COUNT = 4
) (
    input  logic                             user_clk,
    input  logic                             rst,
    input  logic [G_FRAME_WIDTH-1:0]         fclk_data,
    input  logic                             fclk_valid,
    input  logic                             iserdes_rst,
    input  logic                             err_cnt_clr,
    output logic [$clog2(G_FRAME_WIDTH)-1:0] rot_sel,
    output logic                             fclk_locked,
    output logic [G_FRAME_WIDTH-1:0]         fclk_aligned,
    output logic                             fclk_aligned_valid,
    output logic [31:0]                      fclk_err_cnt
);

    localparam int RW = $clog2(G_FRAME_WIDTH);
    localparam int GW = $clog2(G_LOCK_COUNT + 1);
    localparam int WW = $clog2(G_SLIP_WAIT + 1);
    localparam int BW = $clog2(G_UNLOCK_COUNT + 1);

    localparam logic [RW-1:0] ROT_LAST    = RW'(G_FRAME_WIDTH - 1);
    localparam logic [GW-1:0] LOCK_LAST   = GW'(G_LOCK_COUNT);
    localparam logic [WW-1:0] SLIP_LAST   = WW'(G_SLIP_WAIT);
    localparam logic [BW-1:0] UNLOCK_LAST = BW'(G_UNLOCK_COUNT);

    typedef enum logic [1:0] {
        S_SEARCH,
        S_WAIT,
        S_LOCKING,
        S_LOCKED
    } state_t;

    state_t                     state_q, state_d;
    logic [RW-1:0]              rot_q, rot_d, rot_inc;
    logic [GW-1:0]              good_q, good_d;
    logic [WW-1:0]              wait_q, wait_d;
    logic [BW-1:0]              bad_q, bad_d;
    logic                       locked_q, locked_d;
    logic [31:0]                err_q, err_d;
    logic [G_FRAME_WIDTH-1:0]   aligned_q, aligned_d;
    logic                       aligned_valid_q;
    logic [2*G_FRAME_WIDTH-1:0] doubled, shifted;
    logic                       match;

    // Shifting a doubled copy right by rot gives rotated[i] = data[(i + rot) mod W].
    always_comb begin
        doubled   = {fclk_data, fclk_data};
        shifted   = doubled >> rot_q;
        aligned_d = shifted[G_FRAME_WIDTH-1:0];
        match     = (aligned_d == G_FCLK_PATTERN);
        rot_inc   = (rot_q == ROT_LAST) ? '0 : rot_q + 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        rot_d    = rot_q;
        good_d   = good_q;
        wait_d   = wait_q;
        bad_d    = bad_q;
        locked_d = locked_q;
        err_d    = err_q;

        if (iserdes_rst) begin
            state_d  = S_SEARCH;
            rot_d    = '0;
            good_d   = '0;
            wait_d   = '0;
            bad_d    = '0;
            locked_d = 1'b0;
        end else if (fclk_valid) begin
            unique case (state_q)
                S_SEARCH: begin
                    if (match) begin
                        if (G_LOCK_COUNT <= 1) begin
                            state_d  = S_LOCKED;
                            locked_d = 1'b1;
                        end else begin
                            state_d = S_LOCKING;
                            good_d  = GW'(1);
                        end
                    end else begin
                        rot_d   = rot_inc;
                        wait_d  = '0;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_q + 1'b1 == SLIP_LAST) begin
                        wait_d  = '0;
                        state_d = S_SEARCH;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
                S_LOCKING: begin
                    if (match) begin
                        if (good_q + 1'b1 == LOCK_LAST) begin
                            good_d   = '0;
                            state_d  = S_LOCKED;
                            locked_d = 1'b1;
                        end else begin
                            good_d = good_q + 1'b1;
                        end
                    end else begin
                        good_d  = '0;
                        rot_d   = rot_inc;
                        wait_d  = '0;
                        state_d = S_WAIT;
                    end
                end
                S_LOCKED: begin
                    if (match) begin
                        bad_d = '0;
                    end else if (bad_q + 1'b1 == UNLOCK_LAST) begin
                        bad_d    = '0;
                        state_d  = S_SEARCH;
                        locked_d = 1'b0;
                    end else begin
                        bad_d = bad_q + 1'b1;
                    end
                end
                default: state_d = S_SEARCH;
            endcase
        end

        // A clear beats a same-cycle increment; the counter sticks at all-ones.
        if (err_cnt_clr) begin
            err_d = '0;
        end else if (!iserdes_rst && fclk_valid && state_q == S_LOCKED && !match
                     && err_q != 32'hFFFF_FFFF) begin
            err_d = err_q + 32'd1;
        end
    end

    always_ff @(posedge user_clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_SEARCH;
            rot_q           <= '0;
            good_q          <= '0;
            wait_q          <= '0;
            bad_q           <= '0;
            locked_q        <= 1'b0;
            err_q           <= '0;
            aligned_q       <= '0;
            aligned_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            rot_q           <= rot_d;
            good_q          <= good_d;
            wait_q          <= wait_d;
            bad_q           <= bad_d;
            locked_q        <= locked_d;
            err_q           <= err_d;
            aligned_q       <= aligned_d;
            aligned_valid_q <= fclk_valid;
        end
    end

    assign rot_sel            = rot_q;
    assign fclk_locked        = locked_q;
    assign fclk_aligned       = aligned_q;
    assign fclk_aligned_valid = aligned_valid_q;
    assign fclk_err_cnt       = err_q;

endmodule
